// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
//   Shared types for the program-counter sequencer:
//     state_e : FSM states (RUN, HALT)
//     act_e   : per-cycle action selected by the priority decoder
//   Legal range of the return-address stack depth.
// ---------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // One action is taken per cycle. ACT_OVF/ACT_UNF are the faulting
  // forms of call/ret: they only set a sticky flag and enter HALT.
  typedef enum logic [3:0] {
    ACT_HOLD   = 4'd0,
    ACT_INC    = 4'd1,
    ACT_BRANCH = 4'd2,
    ACT_JUMP   = 4'd3,
    ACT_CALL   = 4'd4,
    ACT_RET    = 4'd5,
    ACT_HALT   = 4'd6,
    ACT_RESUME = 4'd7,
    ACT_OVF    = 4'd8,
    ACT_UNF    = 4'd9
  } act_e;

  localparam int STACK_DEPTH_MIN = 2;
  localparam int STACK_DEPTH_MAX = 16;

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Request / status bundle of the program-counter sequencer.
//   master : drives en, branch, offset, jump, call, ret, target, halt, resume;
//            observes pc, halted, err_ovf, err_unf, depth.
//   slave  : the sequencer side (directions mirrored).
//   DEPTH_W must equal $clog2(STACK_DEPTH+1) of the attached sequencer.
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int OFFS_W  = 8,
  parameter int DEPTH_W = 3
);
  logic               en;
  logic               branch;
  logic [OFFS_W-1:0]  offset;
  logic               jump;
  logic               call;
  logic               ret;
  logic [ADDR_W-1:0]  target;
  logic               halt;
  logic               resume;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic               err_ovf;
  logic               err_unf;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output en, branch, offset, jump, call, ret, target, halt, resume,
    input  pc, halted, err_ovf, err_unf, depth
  );

  modport slave (
    input  en, branch, offset, jump, call, ret, target, halt, resume,
    output pc, halted, err_ovf, err_unf, depth
  );
endinterface

// File: rtl/pc_ret_stack.sv
// ---------------------------------------------------------------------------
// pc_ret_stack
//   Return-address LIFO.
//   Ports:
//     clk, reset      : clock, asynchronous active-low reset (clears occupancy)
//     push, push_data : store push_data on top (ignored when full)
//     pop             : discard top entry (ignored when empty; push wins)
//     top             : current top entry (meaningless when empty)
//     depth           : occupancy 0..DEPTH
//     full, empty     : occupancy status
// ---------------------------------------------------------------------------
module pc_ret_stack #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  depth,
  output logic              full,
  output logic              empty
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign wr_idx  = IDX_W'(cnt);
  assign rd_idx  = IDX_W'(cnt - CNT_W'(1));
  assign top     = mem[rd_idx];
  assign depth   = cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + CNT_W'(1);
    end else if (do_pop) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; entries above the occupancy count
  // are never observed, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer with RUN/HALT FSM. Per enabled cycle in RUN it
//   performs one action, priority halt > ret > call > jump > branch > inc.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous active-low reset
//     bus   : pc_sequencer_if.slave (requests in; pc/halted/err_*/depth out)
//   Configuration:
//     PC_CALL_STACK_EN defined   -> return-address stack, call/ret, error flags
//     PC_CALL_STACK_EN undefined -> call acts as jump, ret as increment,
//                                   err_ovf/err_unf/depth tied to 0
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int OFFS_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);
  localparam int SUM_W = ADDR_W + OFFS_W;

  if (STACK_DEPTH < STACK_DEPTH_MIN || STACK_DEPTH > STACK_DEPTH_MAX) begin : g_bad_depth
    $error("pc_sequencer: STACK_DEPTH out of range 2..16");
  end

  state_e            state;
  act_e              act;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_branch;

  assign pc_inc = pc_q + ADDR_W'(1);
  // Offset is sign-extended into a width that holds both operands, then the
  // sum is truncated so the result wraps modulo 2^ADDR_W.
  assign pc_branch = ADDR_W'(SUM_W'(pc_q)
                             + {{ADDR_W{bus.offset[OFFS_W-1]}}, bus.offset}
                             + SUM_W'(1));

`ifdef PC_CALL_STACK_EN
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0]  stk_top;
  logic [DEPTH_W-1:0] stk_depth;
  logic               stk_full;
  logic               stk_empty;
  logic               err_ovf_q;
  logic               err_unf_q;

  pc_ret_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (act == ACT_CALL),
    .pop       (act == ACT_RET),
    .push_data (pc_inc),
    .top       (stk_top),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign bus.err_ovf = err_ovf_q;
  assign bus.err_unf = err_unf_q;
  assign bus.depth   = stk_depth;
`else
  assign bus.err_ovf = 1'b0;
  assign bus.err_unf = 1'b0;
  assign bus.depth   = '0;
`endif

  assign bus.pc     = pc_q;
  assign bus.halted = (state == ST_HALT);

  // NOTE: act gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    act = ACT_HOLD;
    if (bus.en) begin
      if (state == ST_HALT) begin
        if (bus.resume) act = ACT_RESUME;
      end else if (bus.halt) begin
        act = ACT_HALT;
      end else if (bus.ret) begin
`ifdef PC_CALL_STACK_EN
        act = stk_empty ? ACT_UNF : ACT_RET;
`else
        act = ACT_INC;
`endif
      end else if (bus.call) begin
`ifdef PC_CALL_STACK_EN
        act = stk_full ? ACT_OVF : ACT_CALL;
`else
        act = ACT_JUMP;
`endif
      end else if (bus.jump) begin
        act = ACT_JUMP;
      end else if (bus.branch) begin
        act = ACT_BRANCH;
      end else begin
        act = ACT_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      pc_q      <= '0;
`ifdef PC_CALL_STACK_EN
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
`endif
    end else begin
      case (act)
        ACT_INC:    pc_q  <= pc_inc;
        ACT_BRANCH: pc_q  <= pc_branch;
        ACT_JUMP:   pc_q  <= bus.target;
        ACT_HALT:   state <= ST_HALT;
        ACT_RESUME: state <= ST_RUN;
`ifdef PC_CALL_STACK_EN
        ACT_CALL:   pc_q  <= bus.target;
        ACT_RET:    pc_q  <= stk_top;
        ACT_OVF: begin
          err_ovf_q <= 1'b1;
          state     <= ST_HALT;
        end
        ACT_UNF: begin
          err_unf_q <= 1'b1;
          state     <= ST_HALT;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer at default parameters. A queue-based
//   reference model follows the sequencer's rules and is compared against all
//   outputs after every clock. Works with or without PC_CALL_STACK_EN.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
  localparam int ADDR_W      = 8;
  localparam int OFFS_W      = 8;
  localparam int STACK_DEPTH = 4;
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);
  localparam int PC_MOD      = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .OFFS_W(OFFS_W), .DEPTH_W(DEPTH_W)) bus ();

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .OFFS_W      (OFFS_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int unsigned m_pc;
  bit          m_halted;
  bit          m_ovf;
  bit          m_unf;
  int unsigned m_stk[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc     = 0;
    m_halted = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_stk.delete();
  endfunction

  // One enabled-edge update, taken straight from the action rules.
  function automatic void model_step();
    int t;
    if (!bus.en) return;
    if (m_halted) begin
      if (bus.resume) m_halted = 1'b0;
      return;
    end
    if (bus.halt) begin
      m_halted = 1'b1;
    end else if (bus.ret) begin
`ifdef PC_CALL_STACK_EN
      if (m_stk.size() == 0) begin
        m_unf    = 1'b1;
        m_halted = 1'b1;
      end else begin
        m_pc = m_stk.pop_back();
      end
`else
      m_pc = (m_pc + 1) % PC_MOD;
`endif
    end else if (bus.call) begin
`ifdef PC_CALL_STACK_EN
      if (m_stk.size() == STACK_DEPTH) begin
        m_ovf    = 1'b1;
        m_halted = 1'b1;
      end else begin
        m_stk.push_back((m_pc + 1) % PC_MOD);
        m_pc = int'(bus.target);
      end
`else
      m_pc = int'(bus.target);
`endif
    end else if (bus.jump) begin
      m_pc = int'(bus.target);
    end else if (bus.branch) begin
      t    = int'(m_pc) + int'($signed(bus.offset)) + 1;
      m_pc = ((t % PC_MOD) + PC_MOD) % PC_MOD;
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".pc"},      32'(bus.pc),      32'(m_pc));
    check({tag, ".halted"},  32'(bus.halted),  32'(m_halted));
    check({tag, ".err_ovf"}, 32'(bus.err_ovf), 32'(m_ovf));
    check({tag, ".err_unf"}, 32'(bus.err_unf), 32'(m_unf));
    check({tag, ".depth"},   32'(bus.depth),   32'(m_stk.size()));
  endtask

  task automatic idle_inputs();
    bus.en     = 1'b1;
    bus.branch = 1'b0;
    bus.offset = '0;
    bus.jump   = 1'b0;
    bus.call   = 1'b0;
    bus.ret    = 1'b0;
    bus.target = '0;
    bus.halt   = 1'b0;
    bus.resume = 1'b0;
  endtask

  // Apply the currently driven inputs for one edge, then compare.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  // Asserts reset between edges, checks it acts without a clock, releases.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    compare_model("rst_async");
    @(posedge clk);
    #1;
    compare_model("rst_hold");
    reset = 1'b1;
  endtask

  task automatic jump_to(input int tgt);
    idle_inputs();
    bus.jump   = 1'b1;
    bus.target = ADDR_W'(tgt);
    step("jump_to");
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #3;
    do_reset();
    check("reset_pc", 32'(bus.pc), 32'd0);
    check("reset_depth", 32'(bus.depth), 32'd0);

    // Free-running count with wrap
    for (int i = 1; i <= 300; i++) begin
      step("count");
      if (i == 256) check("wrap_pc", 32'(bus.pc), 32'd0);
    end
    check("count300_pc", 32'(bus.pc), 32'd44);
    check("count300_flags", 32'({bus.err_ovf, bus.err_unf, bus.halted}), 32'd0);

    // Relative branches
    jump_to(10);
    bus.branch = 1'b1; bus.offset = OFFS_W'(-3);
    step("br_neg");
    check("br_neg_pc", 32'(bus.pc), 32'd8);
    bus.offset = OFFS_W'(5);
    step("br_pos");
    check("br_pos_pc", 32'(bus.pc), 32'd14);
    jump_to(250);
    bus.branch = 1'b1; bus.offset = OFFS_W'(10);
    step("br_wrap");
    check("br_wrap_pc", 32'(bus.pc), 32'd5);

    // en=0 freezes everything, including halt
    idle_inputs();
    bus.en = 1'b0; bus.jump = 1'b1; bus.target = 8'd33; bus.halt = 1'b1;
    step("stall");
    check("stall_pc", 32'(bus.pc), 32'd5);

    // Halt / resume timing
    idle_inputs();
    bus.halt = 1'b1;
    step("halt");
    check("halt_halted", 32'(bus.halted), 32'd1);
    idle_inputs();
    bus.jump = 1'b1; bus.target = 8'd77;
    step("in_halt");
    bus.en = 1'b0; bus.resume = 1'b1;
    step("resume_stalled");
    idle_inputs();
    bus.resume = 1'b1;
    step("resume");
    check("resume_pc", 32'(bus.pc), 32'd5);
    idle_inputs();
    step("after_resume");

    // Call / return
    jump_to(20);
    bus.call = 1'b1; bus.target = 8'd100;
    step("call");
    check("call_pc", 32'(bus.pc), 32'd100);
    idle_inputs();
    bus.ret = 1'b1;
    step("ret");
`ifdef PC_CALL_STACK_EN
    check("ret_pc", 32'(bus.pc), 32'd21);
`else
    check("ret_pc", 32'(bus.pc), 32'd101);
`endif

    // Nested calls to overflow
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      idle_inputs();
      bus.call = 1'b1; bus.target = ADDR_W'(i * 10);
      step("nest_call");
    end
`ifdef PC_CALL_STACK_EN
    check("ovf_flag", 32'(bus.err_ovf), 32'd1);
    check("ovf_halted", 32'(bus.halted), 32'd1);
    check("ovf_pc", 32'(bus.pc), 32'd40);
    check("ovf_depth", 32'(bus.depth), 32'd4);
`else
    check("nocs_call_pc", 32'(bus.pc), 32'd50);
    check("nocs_depth", 32'(bus.depth), 32'd0);
`endif
    idle_inputs();
    bus.resume = 1'b1;
    step("ovf_resume");
`ifdef PC_CALL_STACK_EN
    check("ovf_sticky", 32'(bus.err_ovf), 32'd1);
`endif
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.ret = 1'b1;
      step("unwind");
    end

    // Underflow with all lower-priority requests present
    do_reset();
    jump_to(7);
    bus.ret = 1'b1; bus.call = 1'b1; bus.jump = 1'b1; bus.branch = 1'b1;
    bus.target = 8'd99; bus.offset = OFFS_W'(5);
    step("prio_ret");
`ifdef PC_CALL_STACK_EN
    check("unf_flag", 32'(bus.err_unf), 32'd1);
    check("unf_pc", 32'(bus.pc), 32'd7);
`else
    check("nocs_ret_pc", 32'(bus.pc), 32'd8);
    idle_inputs();
    bus.halt = 1'b1;
    step("nocs_halt");
`endif
    check("prio_halted", 32'(bus.halted), 32'd1);
    do_reset();
    check("midhalt_rst", 32'({bus.pc, bus.halted, bus.err_ovf, bus.err_unf, bus.depth}), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) do_reset();
      bus.en     = ($urandom_range(0, 99) < 90);
      bus.halt   = ($urandom_range(0, 99) < 4);
      bus.resume = ($urandom_range(0, 99) < 35);
      bus.ret    = ($urandom_range(0, 99) < 12);
      bus.call   = ($urandom_range(0, 99) < 12);
      bus.jump   = ($urandom_range(0, 99) < 10);
      bus.branch = ($urandom_range(0, 99) < 25);
      bus.offset = OFFS_W'($urandom_range(0, 255));
      bus.target = ADDR_W'($urandom_range(0, 255));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
